// File: rtl/request_returner.sv
// Completion return buffer: collects out-of-order read/write completions by slot
// and hands them back to the requester in per-type slot order, arbitrating reads vs writes.
module request_returner #(
  parameter int READ_ENTRIES  = 16,
  parameter int WRITE_ENTRIES = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int IDX_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmp_valid,
  input  logic                  cmp_type,
  input  logic [IDX_W-1:0]      cmp_index,
  input  logic [DATA_WIDTH-1:0] cmp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_type,
  output logic [IDX_W-1:0]      out_index,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            done,
  output logic                  err_dup
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(READ_ENTRIES - 1);
  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(WRITE_ENTRIES - 1);

  state_t                  state_reg;
  logic [READ_ENTRIES-1:0] rd_valid_reg;
  logic [READ_ENTRIES-1:0] rd_valid_next;
  logic [WRITE_ENTRIES-1:0] wr_valid_reg;
  logic [WRITE_ENTRIES-1:0] wr_valid_next;
  logic [DATA_WIDTH-1:0]   rd_mem [READ_ENTRIES];
  logic [IDX_W-1:0]        rd_head_reg;
  logic [IDX_W-1:0]        wr_head_reg;
  logic                    rr_read_turn_reg;
  logic                    out_valid_reg;
  logic                    out_type_reg;
  logic [IDX_W-1:0]        out_index_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic                    err_dup_reg;

  logic [31:0]      cmp_index_ext;
  logic             cmp_rd;
  logic             cmp_wr;
  logic             rd_in_range;
  logic             wr_in_range;
  logic             rd_accept;
  logic             wr_accept;
  logic             dup_hit;
  logic             handshake;
  logic             rd_served;
  logic             wr_served;
  logic [IDX_W-1:0] rd_head_inc;
  logic [IDX_W-1:0] wr_head_inc;
  logic             rd_elig;
  logic             wr_elig;
  logic             rd_elig_after;
  logic             wr_elig_after;
  logic             pick_read;

  // Completion intake; a hit on an already-valid slot (including the one being served) is a duplicate.
  assign cmp_index_ext = 32'(cmp_index);
  assign cmp_rd        = cmp_valid & ~rst & ~cmp_type;
  assign cmp_wr        = cmp_valid & ~rst & cmp_type;
  assign rd_in_range   = cmp_index_ext < 32'(READ_ENTRIES);
  assign wr_in_range   = cmp_index_ext < 32'(WRITE_ENTRIES);
  assign rd_accept     = cmp_rd & rd_in_range & ~rd_valid_reg[cmp_index];
  assign wr_accept     = cmp_wr & wr_in_range & ~wr_valid_reg[cmp_index];
  assign dup_hit       = (cmp_rd & ~rd_accept) | (cmp_wr & ~wr_accept);

  assign handshake = out_valid_reg & out_ready & ~rst;
  assign rd_served = handshake & ~out_type_reg;
  assign wr_served = handshake & out_type_reg;

  assign rd_head_inc = (rd_head_reg == RD_LAST) ? '0 : rd_head_reg + IDX_W'(1);
  assign wr_head_inc = (wr_head_reg == WR_LAST) ? '0 : wr_head_reg + IDX_W'(1);

  assign rd_elig       = rd_valid_reg[rd_head_reg];
  assign wr_elig       = wr_valid_reg[wr_head_reg];
  assign rd_elig_after = rd_served ? rd_valid_reg[rd_head_inc] : rd_elig;
  assign wr_elig_after = wr_served ? wr_valid_reg[wr_head_inc] : wr_elig;
  assign pick_read     = rd_elig & (~wr_elig | rr_read_turn_reg);

  genvar gi;
  generate
    for (gi = 0; gi < READ_ENTRIES; gi++) begin : g_rd_valid
      assign rd_valid_next[gi] =
          (rd_served && rd_head_reg == IDX_W'(gi)) ? 1'b0 :
          (rd_accept && cmp_index == IDX_W'(gi))   ? 1'b1 : rd_valid_reg[gi];
    end
    for (gi = 0; gi < WRITE_ENTRIES; gi++) begin : g_wr_valid
      assign wr_valid_next[gi] =
          (wr_served && wr_head_reg == IDX_W'(gi)) ? 1'b0 :
          (wr_accept && cmp_index == IDX_W'(gi))   ? 1'b1 : wr_valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= '0;
      wr_valid_reg <= '0;
    end else begin
      rd_valid_reg <= rd_valid_next;
      wr_valid_reg <= wr_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      rd_mem[cmp_index] <= cmp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      rd_head_reg      <= '0;
      wr_head_reg      <= '0;
      rr_read_turn_reg <= 1'b1;
      out_valid_reg    <= 1'b0;
      out_type_reg     <= 1'b0;
      out_index_reg    <= '0;
      out_data_reg     <= '0;
      err_dup_reg      <= 1'b0;
    end else begin
      if (dup_hit) begin
        err_dup_reg <= 1'b1;
      end
      if (rd_served) begin
        rd_head_reg <= rd_head_inc;
      end
      if (wr_served) begin
        wr_head_reg <= wr_head_inc;
      end

      case (state_reg)
        IDLE: begin
          if (rd_elig || wr_elig) begin
            state_reg     <= PRESENT;
            out_valid_reg <= 1'b1;
            out_type_reg  <= ~pick_read;
            out_index_reg <= pick_read ? rd_head_reg : wr_head_reg;
            out_data_reg  <= pick_read ? rd_mem[rd_head_reg] : '0;
            // The turn only moves when both types actually competed.
            if (rd_elig && wr_elig) begin
              rr_read_turn_reg <= ~pick_read;
            end
          end
        end
        PRESENT: begin
          if (out_valid_reg) begin
            if (handshake) begin
              out_valid_reg <= 1'b0;
              if (!(rd_elig_after || wr_elig_after)) begin
                state_reg <= IDLE;
              end
            end
          end else if (rd_elig || wr_elig) begin
            out_valid_reg <= 1'b1;
            out_type_reg  <= ~pick_read;
            out_index_reg <= pick_read ? rd_head_reg : wr_head_reg;
            out_data_reg  <= pick_read ? rd_mem[rd_head_reg] : '0;
            if (rd_elig && wr_elig) begin
              rr_read_turn_reg <= ~pick_read;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_type  = out_type_reg;
  assign out_index = out_index_reg;
  assign out_data  = out_data_reg;
  assign done      = {wr_served, rd_served};
  assign err_dup   = err_dup_reg;

endmodule

// File: tb/tb_request_returner.sv
// Directed bench for request_returner: ordering, arbitration, stall, duplicates, wrap and reset.
module tb_request_returner;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmp_valid;
  logic          cmp_type;
  logic [IW-1:0] cmp_index;
  logic [DW-1:0] cmp_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_type;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic [1:0]    done;
  logic          err_dup;

  typedef struct packed {
    logic          t;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t log_q[$];
  int   d0_cnt = 0;
  int   d1_cnt = 0;
  int   both_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  request_returner #(
    .READ_ENTRIES (16),
    .WRITE_ENTRIES(16),
    .DATA_WIDTH   (DW),
    .IDX_W        (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmp_valid(cmp_valid),
    .cmp_type (cmp_type),
    .cmp_index(cmp_index),
    .cmp_data (cmp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_type (out_type),
    .out_index(out_index),
    .out_data (out_data),
    .done     (done),
    .err_dup  (err_dup)
  );

  always #5 clk = ~clk;

  // Observe handshakes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (done[0]) d0_cnt++;
    if (done[1]) d1_cnt++;
    if (done == 2'b11) both_cnt++;
    if (out_valid && out_ready && !rst) begin
      log_q.push_back('{t: out_type, idx: out_index, data: out_data});
      $display("rsp type=%0d idx=%0d data=%08h done=%b", out_type, out_index, out_data, done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic t, input int idx, input logic [DW-1:0] d);
    cmp_valid = 1'b1;
    cmp_type  = t;
    cmp_index = IW'(idx);
    cmp_data  = d;
    tick();
    cmp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input int k, input logic t, input int idx,
                         input logic [DW-1:0] d);
    rsp_t r;
    r = (k < log_q.size()) ? log_q[k] : '0;
    chk({tag, "_type"}, 64'(r.t), 64'(t));
    chk({tag, "_idx"}, 64'(r.idx), 64'(idx));
    chk({tag, "_data"}, 64'(r.data), 64'(d));
  endtask

  task automatic hold_chk();
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_idx", 64'(out_index), 64'd0);
    chk("stall_data", 64'(out_data), 64'h3300);
    chk("stall_done", 64'(done), 64'd0);
  endtask

  initial begin
    int base;
    int b0;
    int b1;
    int bb;

    rst       = 1'b1;
    cmp_valid = 1'b0;
    cmp_type  = 1'b0;
    cmp_index = '0;
    cmp_data  = '0;
    out_ready = 1'b0;
    tick();
    // A completion presented during reset must be ignored.
    cmp_valid = 1'b1;
    cmp_index = 4'd5;
    cmp_data  = 32'h5555;
    tick();
    tick();
    cmp_valid = 1'b0;
    rst       = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_type", 64'(out_type), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_dup", 64'(err_dup), 64'd0);
    tick();
    tick();
    chk("rst_cmp_ignored_valid", 64'(out_valid), 64'd0);
    chk("rst_cmp_ignored_bits", 64'(dut.rd_valid_reg), 64'd0);

    // Single read: one-edge latency from capture to out_valid.
    out_ready = 1'b1;
    send(1'b0, 0, 32'hA5A5_0001);
    chk("lat_not_early", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_index", 64'(out_index), 64'd0);
    chk("t1_type", 64'(out_type), 64'd0);
    chk("t1_data", 64'(out_data), 64'hA5A5_0001);
    chk("t1_done", 64'(done), 64'b01);
    tick();
    chk("t1_done_off", 64'(done), 64'd0);
    chk("t1_valid_off", 64'(out_valid), 64'd0);
    chk("t1_rd_head", 64'(dut.rd_head_reg), 64'd1);

    // Out-of-order arrival, in-order return.
    do_reset();
    base = log_q.size();
    out_ready = 1'b1;
    send(1'b0, 2, 32'h2222);
    send(1'b0, 1, 32'h1111);
    repeat (3) tick();
    chk("ooo_blocked_count", 64'(log_q.size() - base), 64'd0);
    chk("ooo_blocked_valid", 64'(out_valid), 64'd0);
    send(1'b0, 0, 32'h1000);
    repeat (10) tick();
    chk("ooo_count", 64'(log_q.size() - base), 64'd3);
    chk_rsp("ooo0", base + 0, 1'b0, 0, 32'h1000);
    chk_rsp("ooo1", base + 1, 1'b0, 1, 32'h1111);
    chk_rsp("ooo2", base + 2, 1'b0, 2, 32'h2222);

    // Stall with a pending read, then round-robin between reads and writes.
    do_reset();
    base = log_q.size();
    b0 = d0_cnt;
    b1 = d1_cnt;
    bb = both_cnt;
    out_ready = 1'b0;
    send(1'b0, 0, 32'h3300);
    send(1'b1, 0, 32'hDEAD);
    hold_chk();
    send(1'b1, 1, 32'hBEEF);
    hold_chk();
    send(1'b0, 1, 32'h3301);
    hold_chk();
    send(1'b0, 2, 32'h3302);
    hold_chk();
    tick();
    hold_chk();
    out_ready = 1'b1;
    #1;
    chk("stall_release_done", 64'(done), 64'b01);
    tick();
    chk("stall_one_done", 64'(done), 64'd0);
    chk("stall_valid_drop", 64'(out_valid), 64'd0);
    repeat (12) tick();
    chk("rr_count", 64'(log_q.size() - base), 64'd5);
    chk_rsp("rr0", base + 0, 1'b0, 0, 32'h3300);
    chk_rsp("rr1", base + 1, 1'b0, 1, 32'h3301);
    chk_rsp("rr2", base + 2, 1'b1, 0, 32'h0);
    chk_rsp("rr3", base + 3, 1'b0, 2, 32'h3302);
    chk_rsp("rr4", base + 4, 1'b1, 1, 32'h0);
    chk("rr_done0", 64'(d0_cnt - b0), 64'd3);
    chk("rr_done1", 64'(d1_cnt - b1), 64'd2);
    chk("rr_done_both", 64'(both_cnt - bb), 64'd0);

    // Duplicate completion keeps original data and sets the sticky flag.
    do_reset();
    base = log_q.size();
    b0 = d0_cnt;
    out_ready = 1'b0;
    send(1'b0, 3, 32'h3333);
    chk("dup_err_before", 64'(err_dup), 64'd0);
    send(1'b0, 3, 32'hBAD0);
    chk("dup_err_set", 64'(err_dup), 64'd1);
    out_ready = 1'b1;
    send(1'b0, 0, 32'h3000);
    send(1'b0, 1, 32'h3001);
    send(1'b0, 2, 32'h3002);
    repeat (12) tick();
    chk("dup_count", 64'(log_q.size() - base), 64'd4);
    chk_rsp("dup0", base + 0, 1'b0, 0, 32'h3000);
    chk_rsp("dup1", base + 1, 1'b0, 1, 32'h3001);
    chk_rsp("dup2", base + 2, 1'b0, 2, 32'h3002);
    chk_rsp("dup3", base + 3, 1'b0, 3, 32'h3333);
    chk("dup_done0", 64'(d0_cnt - b0), 64'd4);
    chk("dup_err_sticky", 64'(err_dup), 64'd1);

    // Seventeen reads through the ring: head wraps 15 -> 0.
    do_reset();
    base = log_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(1'b0, i % 16, 32'h600 + 32'(i));
      repeat (3) tick();
      chk("wrap_head", 64'(dut.rd_head_reg), 64'((i + 1) % 16));
    end
    chk("wrap_count", 64'(log_q.size() - base), 64'd17);
    for (int k = 0; k < 17; k++) begin
      chk_rsp("wrap_rsp", base + k, 1'b0, k % 16, 32'h600 + 32'(k));
    end

    // Reset while a response is presented drops it with no done pulse.
    out_ready = 1'b0;
    send(1'b0, 1, 32'h7777);
    tick();
    chk("prst_valid", 64'(out_valid), 64'd1);
    chk("prst_index", 64'(out_index), 64'd1);
    b0 = d0_cnt;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("prst_no_done_in_rst", 64'(done), 64'd0);
    tick();
    chk("prst_out_valid", 64'(out_valid), 64'd0);
    chk("prst_out_type", 64'(out_type), 64'd0);
    chk("prst_out_index", 64'(out_index), 64'd0);
    chk("prst_out_data", 64'(out_data), 64'd0);
    chk("prst_done", 64'(done), 64'd0);
    chk("prst_rd_head", 64'(dut.rd_head_reg), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("prst_no_done_after", 64'(d0_cnt - b0), 64'd0);
    chk("prst_stays_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
